// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-add multiplier with its own control FSM: one add-and-shift step per clock.
// Optional timeout abort (driven by the cycle counter's k flag) is built when MULT_TIMEOUT_EN is defined.
module seq_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 k,
  output logic                 cnt_clr,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = $clog2(WIDTH) + 1;

`ifdef MULT_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Debug view of the control state for checkers bound to this block.
  typedef struct packed {
    state_t          state;
    logic [IW-1:0]   iter;
  } dbg_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH:0]     acc_q;
  logic [IW-1:0]        iter_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 cnt_clr_q;
  dbg_t                 dbg;

  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH:0]     acc_sum;
  logic [2*WIDTH:0]     acc_d;
  logic                 last_iter;
  logic                 abort;

  // Upper half plus multiplicand (when the current multiplier bit is set), then shift right by one.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    end
    acc_sum   = {add_sum, acc_q[WIDTH-1:0]};
    acc_d     = acc_sum >> 1;
    last_iter = (iter_q == IW'(WIDTH - 1));
    abort     = TIMEOUT_EN && k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_clr_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (st) begin
            m_q       <= a;
            acc_q     <= {1'b0, {WIDTH{1'b0}}, b};
            iter_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            cnt_clr_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          iter_q <= iter_q + 1'b1;
          if (last_iter) begin
            // Completion takes priority over a coincident timeout.
            product_q <= acc_d[2*WIDTH-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            cnt_clr_q <= 1'b1;
            state_q   <= IDLE;
          end else if (abort) begin
            err_q     <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cnt_clr_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          cnt_clr_q <= 1'b1;
        end
      endcase
    end
  end

  assign dbg.state = state_q;
  assign dbg.iter  = iter_q;

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign err     = TIMEOUT_EN ? err_q : 1'b0;
  assign cnt_clr = TIMEOUT_EN ? cnt_clr_q : 1'b1;

  logic unused_dbg;
  assign unused_dbg = ^dbg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: directed steps plus random operands against a plain-arithmetic model.
module tb_seq_mult_ctrl;

  localparam int W = 16;

`ifdef MULT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             st;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             k;
  logic             cnt_clr;
  logic [2*W-1:0]   product;
  logic             done;
  logic             busy;
  logic             err;

  int passed;
  int total;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_prod;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .st      (st),
    .a       (a),
    .b       (b),
    .k       (k),
    .cnt_clr (cnt_clr),
    .product (product),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; optionally pulses st (a=9,b=9) at iteration pulse_at, holds k at k_all.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int pulse_at, input logic k_all);
    a  = ta;
    b  = tb_v;
    st = 1'b1;
    k  = k_all;
    exp_q.push_back(ref_mul(ta, tb_v));
    step();
    st = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cnt_clr_run", 32'(cnt_clr), TO_EN ? 32'd0 : 32'd1);
    for (int i = 1; i <= W; i++) begin
      if (i == pulse_at) begin
        st = 1'b1;
        a  = 16'd9;
        b  = 16'd9;
      end
      step();
      st = 1'b0;
      if (i < W) begin
        chk("busy_mid", 32'(busy), 32'd1);
        chk("done_mid", 32'(done), 32'd0);
      end else begin
        exp_prod = exp_q.pop_front();
        chk("done_end", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("err_end", 32'(err), 32'd0);
        chk("cnt_clr_end", 32'(cnt_clr), 32'd1);
        chk("product", product, exp_prod);
      end
    end
    k = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; st = 1'b1; k = 1'b1; a = 16'hAAAA; b = 16'h5555;

    // Reset held two edges with st and k asserted.
    step();
    step();
    chk("rst_product", product, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
    rst = 1'b0; st = 1'b0; k = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Max operands, then done must stay high while idle.
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    chk("max_const", product, 32'hFFFE0001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("done_sticky", 32'(done), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
    end

    run_op(16'd3, 16'd5, 0, 1'b0);
    run_op(16'd0, 16'd1234, 7, 1'b0);
    step();
    chk("ignored_st_busy", 32'(busy), 32'd0);
    chk("ignored_st_product", product, 32'd0);

    // Random operands against the arithmetic model.
    for (int n = 0; n < 6; n++) begin
      run_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), 0, 1'b0);
      step();
    end

    // st held high: back-to-back operations with one-cycle done pulses.
    a = 16'd7; b = 16'd6; st = 1'b1;
    step();
    for (int op = 0; op < 2; op++) begin
      for (int i = 1; i <= W; i++) step();
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_product", product, 32'd42);
      step();
      chk("b2b_done_clear", 32'(done), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd1);
    end
    st = 1'b0;

    // Reset at iteration 8 of the third operation.
    for (int i = 1; i < 8; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_cnt_clr", 32'(cnt_clr), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("post_rst_done", 32'(done), 32'd0);
    end

`ifdef MULT_TIMEOUT_EN
    run_op(16'd3, 16'd5, 0, 1'b0);
    a = 16'd1234; b = 16'd4321; st = 1'b1;
    step();
    st = 1'b0;
    for (int i = 1; i < 5; i++) step();
    k = 1'b1;
    step();
    k = 1'b0;
    chk("to_err", 32'(err), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_product", product, 32'd15);
    chk("to_cnt_clr", 32'(cnt_clr), 32'd1);
    step();
    chk("to_stays_idle", 32'(busy), 32'd0);
    a = 16'd3; b = 16'd5; st = 1'b1;
    step();
    st = 1'b0;
    chk("to2_clear_err", 32'(err), 32'd0);
    for (int i = 1; i < W; i++) step();
    k = 1'b1;
    step();
    k = 1'b0;
    chk("final_k_done", 32'(done), 32'd1);
    chk("final_k_err", 32'(err), 32'd0);
    chk("final_k_product", product, ref_mul(16'd3, 16'd5));
`else
    run_op(16'd100, 16'd200, 0, 1'b1);
    chk("nok_const", product, 32'd20000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Sequential unsigned shift-add multiplier with its own control FSM, inside the multiplier subsystem.
- Consumes the overflow/timeout flag produced by the cycle counter stage, and drives that counter's clear input.
- Computes one partial-product add-and-shift per clock.
- Presents a registered 2*WIDTH-bit product with a sticky done flag.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- st  input  1  start request; sampled only when not busy.
- a  input  WIDTH  multiplicand, captured on the accepted-st edge.
- b  input  WIDTH  multiplier, captured on the accepted-st edge.
- k  input  1  timeout flag from the cycle counter's output.
- cnt_clr  output  1  clear to the cycle counter's clear input; high = counter held at zero.
- product  output  2*WIDTH  last completed result, registered.
- done  output  1  sticky completion flag.
- busy  output  1  high while an operation is in progress.
- err  output  1  sticky timeout-abort flag.

Behaviour:
- Reset: rst=1 at a rising edge forces:
  - state IDLE;
  - product=0, done=0, busy=0, err=0, cnt_clr=1;
  - internal M, acc and iteration counter all zero.
  - rst overrides st and k. Reset mid-operation discards the operation; no done is produced.
- Internal registers:
  - M (WIDTH): latched multiplicand.
  - acc (2*WIDTH+1): {carry, upper WIDTH, lower WIDTH}.
  - iter (clog2(WIDTH)+1 bits).
- State IDLE:
  - busy=0, cnt_clr=1.
  - On st=1: M<=a, acc<={0, WIDTH zeros, b}, iter<=0, done<=0, err<=0, go to RUN.
  - product is unchanged.
- State RUN:
  - busy=1, cnt_clr=0.
  - Every edge, if acc[0]=1: upper is replaced by upper+M, with the carry in bit 2*WIDTH (WIDTH+1-bit sum). Otherwise upper is unchanged.
  - The 2*WIDTH+1-bit result is then shifted right by one and stored in acc. iter<=iter+1.
  - On the edge where iter==WIDTH-1 (final iteration): product<=shifted result[2*WIDTH-1:0], done<=1, go to IDLE.
- Latency:
  - The st-accepting edge is edge 0. Iterations run on edges 1..WIDTH.
  - done and product are visible after edge WIDTH.
  - busy is high for exactly WIDTH cycles.
- No early termination: zero operands still take WIDTH iterations.
- st while busy is ignored (not queued).
- st held high continuously produces back-to-back operations: a new operation is accepted on the first IDLE edge after completion, and done is cleared on that edge.
- done and err are mutually exclusive and stay high until the next accepted st or rst.
- Arithmetic is unsigned and modulo-free: the full 2*WIDTH product is always exact.

Optional Feature:
- Macro MULT_TIMEOUT_EN.
- Defined:
  - k=1 sampled in RUN on a non-final iteration aborts the operation: go to IDLE, err<=1, done<=0, product unchanged, busy<=0, cnt_clr<=1.
  - On the final-iteration edge, normal completion wins and k is ignored.
  - k is ignored in IDLE.
- Undefined:
  - k is unused, err is tied 0, cnt_clr is tied 1.
  - FSM behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=1 for 2 edges with st=1, k=1 -> product=0, done=0, busy=0, err=0, cnt_clr=1; no operation starts.
- Max operands: WIDTH=16, a=16'hFFFF, b=16'hFFFF, one-cycle st -> busy=1 for exactly 16 cycles; done=1 and product=32'hFFFE0001 after edge 16; done stays high with st=0 for 10 further cycles.
- Small values, zero operand and busy behaviour:
  - a=3, b=5 -> product=15.
  - Then a=0, b=16'd1234 -> product=0 after the same 16-cycle latency.
  - Pulse st at iteration 7 with a=9, b=9 -> ignored; product remains 0.
- Continuous start and mid-operation reset:
  - Hold st=1 with a=7, b=6 -> done pulses for one cycle at each back-to-back completion; product=42.
  - Assert rst at iteration 8 -> all outputs reset on that edge; no done.
- With MULT_TIMEOUT_EN:
  - Prior product=15; k=1 at iteration 5 -> err=1, done=0, product=15, busy=0, cnt_clr=1 next cycle.
  - k=1 coincident with the final iteration (a=3, b=5) -> done=1, err=0, product=15.
  - cnt_clr=0 only during RUN.
- Without MULT_TIMEOUT_EN: k=1 held throughout, a=100, b=200 -> product=20000, done=1, err=0, cnt_clr=1 constantly.
